// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. The unit issues single-cycle instruction memory
// reads at the address presented by the program counter. It holds returned
// words, each tagged with its fetch address, in a small FIFO that feeds decode.
//
// Ports
//   CLK          in   1    sole clock, rising edge
//   init_n       in   1    synchronous active-low reset
//   PC           in   AW   address to fetch
//   halt         in   1    stop issuing new fetches (in-flight/buffered drain)
//   flush        in   1    branch taken: drop buffered and in-flight fetches
//   pc_ack       out  1    fetch issued this cycle, PC may advance
//   imem_addr    out  AW   memory read address (always equal to PC)
//   imem_rd      out  1    memory read strobe
//   imem_rdata   in   IW   read data, valid one cycle after imem_rd
//   instr        out  IW   head-of-buffer instruction (0 when empty)
//   instr_pc     out  AW   address of instr (0 when empty)
//   instr_valid  out  1    buffer non-empty
//   dec_ready    in   1    decode consumes instr this cycle
//   done         out  1    halted with buffer empty and nothing in flight
//   fetch_count  out  16   saturating count of instructions handed to decode
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned AW    = 10,
    parameter int unsigned IW    = 9,
    parameter int unsigned DEPTH = 2
) (
    input  logic          CLK,
    input  logic          init_n,
    input  logic [AW-1:0] PC,
    input  logic          halt,
    input  logic          flush,
    output logic          pc_ack,
    output logic [AW-1:0] imem_addr,
    output logic          imem_rd,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          dec_ready,
    output logic          done,
    output logic [15:0]   fetch_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DepthC = cnt_t'(DEPTH);

    // Buffer storage (no reset needed: validity is tracked by count_q)
    logic [IW-1:0] data_q [DEPTH];
    logic [AW-1:0] addr_q [DEPTH];

    // Control state
    ptr_t          rd_ptr_q, rd_ptr_d;
    ptr_t          wr_ptr_q, wr_ptr_d;
    cnt_t          count_q, count_d;
    logic          inflight_q, inflight_d;
    logic [AW-1:0] infl_addr_q, infl_addr_d;
    logic          done_q, done_d;
    logic [15:0]   fetch_count_q, fetch_count_d;

    // Per-cycle events
    logic          pop;
    logic          push;
    logic          issue;
    cnt_t          occ;

    // -------------------------------------------------------------------------
    // Next-state and issue logic
    // -------------------------------------------------------------------------
    always_comb begin
        pop           = 1'b0;
        push          = 1'b0;
        issue         = 1'b0;
        occ           = '0;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        inflight_d    = 1'b0;
        infl_addr_d   = infl_addr_q;
        fetch_count_d = fetch_count_q;
        done_d        = 1'b0;

        pop = (count_q != '0) && dec_ready;

        // Slots that will be occupied after this edge if nothing new is issued:
        // the pending read lands in the buffer and a pop frees its entry.
        occ = count_q + cnt_t'(inflight_q) - cnt_t'(pop);

        issue = init_n && !halt && !flush && (occ < DepthC);

        // A read completing in a flush cycle belongs to the wrong path.
        push = inflight_q && !flush;

        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
        end

        inflight_d = issue;
        if (issue) begin
            infl_addr_d = PC;
        end

        // A pop in a flush cycle still reached decode, so it is counted.
        if (pop && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end

        // Judged on the state this edge produces, so a flush is already applied.
        done_d = halt && (count_d == '0) && !inflight_d;
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!init_n) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            infl_addr_q   <= '0;
            done_q        <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            infl_addr_q   <= infl_addr_d;
            done_q        <= done_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Buffer storage
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (init_n && push) begin
            data_q[wr_ptr_q] <= imem_rdata;
            addr_q[wr_ptr_q] <= infl_addr_q;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        pc_ack      = issue;
        imem_rd     = issue;
        imem_addr   = PC;
        instr_valid = (count_q != '0);
        instr       = '0;
        instr_pc    = '0;
        if (count_q != '0) begin
            instr    = data_q[rd_ptr_q];
            instr_pc = addr_q[rd_ptr_q];
        end
        done        = done_q;
        fetch_count = fetch_count_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Drives fetch_unit cycle by cycle and compares every output against a
// queue-based reference model of the fetch buffer. The bench also plays the
// program counter (advances on pc_ack) and the instruction memory.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int AW    = 10;
    localparam int IW    = 9;
    localparam int DEPTH = 2;

    logic          CLK;
    logic          init_n;
    logic [AW-1:0] PC;
    logic          halt;
    logic          flush;
    logic          pc_ack;
    logic [AW-1:0] imem_addr;
    logic          imem_rd;
    logic [IW-1:0] imem_rdata;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          dec_ready;
    logic          done;
    logic [15:0]   fetch_count;

    fetch_unit #(
        .AW    (AW),
        .IW    (IW),
        .DEPTH (DEPTH)
    ) dut (
        .CLK         (CLK),
        .init_n      (init_n),
        .PC          (PC),
        .halt        (halt),
        .flush       (flush),
        .pc_ack      (pc_ack),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .dec_ready   (dec_ready),
        .done        (done),
        .fetch_count (fetch_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model state
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] data;
    } ent_t;

    ent_t          q[$];
    bit            pend_v;
    logic [AW-1:0] pend_pc;
    bit            done_m;
    int unsigned   cnt_m;
    bit            known;

    logic [AW-1:0] pc_reg;
    int            n_checks;
    int            n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'd37 + 32'd11;
        return t[IW-1:0];
    endfunction

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic cycle();
        bit            pop;
        bit            issue;
        int            occ;
        ent_t          e;
        logic [31:0]   r;
        logic [IW-1:0] rd_next;

        PC = pc_reg;
        #2;
        pop   = 1'b0;
        issue = 1'b0;
        if (known) begin
            pop   = init_n && (q.size() != 0) && dec_ready;
            occ   = int'(q.size()) + int'(pend_v) - int'(pop);
            issue = init_n && !halt && !flush && (occ < DEPTH);
            check_eq("pc_ack", 32'(pc_ack), 32'(issue));
            check_eq("imem_rd", 32'(imem_rd), 32'(issue));
            check_eq("imem_addr", 32'(imem_addr), 32'(PC));
            check_eq("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
            check_eq("instr", 32'(instr), (q.size() != 0) ? 32'(q[0].data) : 32'd0);
            check_eq("instr_pc", 32'(instr_pc), (q.size() != 0) ? 32'(q[0].pc) : 32'd0);
            check_eq("done", 32'(done), 32'(done_m));
            check_eq("fetch_count", 32'(fetch_count), 32'(cnt_m));
        end

        // Memory returns the addressed word after a read, garbage otherwise.
        r = $urandom();
        rd_next = issue ? mem_word(PC) : r[IW-1:0];

        if (!init_n) begin
            q.delete();
            pend_v = 1'b0;
            done_m = 1'b0;
            cnt_m  = 0;
            known  = 1'b1;
        end else begin
            if (pop) begin
                q.delete(0);
                if (cnt_m < 65535) cnt_m++;
            end
            if (flush) begin
                q.delete();
                pend_v = 1'b0;
            end else begin
                if (pend_v) begin
                    e.pc   = pend_pc;
                    e.data = imem_rdata;
                    q.push_back(e);
                end
                pend_v  = issue;
                pend_pc = PC;
            end
            done_m = halt && (q.size() == 0) && !pend_v;
        end

        @(posedge CLK);
        #1;
        imem_rdata = rd_next;
        if (issue) pc_reg = pc_reg + 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic [15:0] fc_save;
        logic [31:0] r;

        n_checks   = 0;
        n_fail     = 0;
        known      = 1'b0;
        pend_v     = 1'b0;
        pend_pc    = '0;
        done_m     = 1'b0;
        cnt_m      = 0;
        init_n     = 1'b0;
        halt       = 1'b0;
        flush      = 1'b0;
        dec_ready  = 1'b0;
        PC         = '0;
        pc_reg     = '0;
        imem_rdata = '0;

        @(posedge CLK);
        #1;

        // Reset
        run(2);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", 32'(instr), 32'd0);
        check_eq("rst_instr_pc", 32'(instr_pc), 32'd0);
        check_eq("rst_fetch_count", 32'(fetch_count), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_pc_ack", 32'(pc_ack), 32'd0);

        // Streaming PC 0..3 then halt and drain
        init_n    = 1'b1;
        pc_reg    = '0;
        dec_ready = 1'b1;
        run(4);
        halt = 1'b1;
        run(4);
        check_eq("stream_fetch_count", 32'(fetch_count), 32'd4);
        check_eq("stream_done", 32'(done), 32'd1);

        // Backpressure: buffer fills to DEPTH and issue stops
        halt      = 1'b0;
        dec_ready = 1'b0;
        run(5);
        check_eq("bp_instr_valid", 32'(instr_valid), 32'd1);
        check_eq("bp_pc_ack", 32'(pc_ack), 32'd0);
        dec_ready = 1'b1;
        run(6);

        // Flush: buffer holds 5,6 then branch to 20
        dec_ready = 1'b0;
        pc_reg    = 10'd5;
        flush     = 1'b1;
        run(1);
        flush = 1'b0;
        run(4);
        check_eq("fl_head_pc", 32'(instr_pc), 32'd5);
        fc_save = fetch_count;
        pc_reg  = 10'd20;
        flush   = 1'b1;
        run(1);
        flush = 1'b0;
        check_eq("fl_count_kept", 32'(fetch_count), 32'(fc_save));
        check_eq("fl_empty", 32'(instr_valid), 32'd0);
        dec_ready = 1'b1;
        run(2);
        check_eq("fl_new_pc", 32'(instr_pc), 32'd20);
        run(3);

        // Halt with one buffered and one in flight
        halt = 1'b1;
        run(4);
        halt      = 1'b0;
        dec_ready = 1'b0;
        fc_save   = fetch_count;
        run(2);
        halt      = 1'b1;
        dec_ready = 1'b1;
        run(3);
        check_eq("halt_done", 32'(done), 32'd1);
        check_eq("halt_delivered", 32'(fetch_count), 32'(fc_save) + 32'd2);
        check_eq("halt_pc_ack", 32'(pc_ack), 32'd0);

        // Reset mid-stream with a read in flight
        halt = 1'b0;
        run(3);
        init_n = 1'b0;
        run(1);
        init_n = 1'b1;
        check_eq("mrst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("mrst_instr", 32'(instr), 32'd0);
        check_eq("mrst_instr_pc", 32'(instr_pc), 32'd0);
        check_eq("mrst_fetch_count", 32'(fetch_count), 32'd0);
        check_eq("mrst_done", 32'(done), 32'd0);
        run(4);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            init_n    = ($urandom_range(99) != 0);
            halt      = ($urandom_range(9) == 0);
            flush     = ($urandom_range(19) == 0);
            dec_ready = ($urandom_range(9) < 7);
            if (flush) begin
                r      = $urandom();
                pc_reg = r[AW-1:0];
            end
            cycle();
        end

        // Saturation of fetch_count
        init_n    = 1'b1;
        halt      = 1'b0;
        flush     = 1'b0;
        dec_ready = 1'b1;
        run(65600);
        check_eq("sat_fetch_count", 32'(fetch_count), 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
